udp2rgb_depack: RTL
===================

// Module: udp2rgb_depack
// PURPOSE
//  Receive-side counterpart of the RGB-to-UDP packetizer: parses UDP payload byte stream back into
//  addressed pixel writes. Each packet = SYNC_HI, SYNC_LO, ROW[15:8], ROW[7:0], then exactly COLS pixel
//  bytes, last byte flagged by rx_last. Sits between the Ethernet/UDP RX core and frame buffer/HDMI path.
//  Drops malformed packets and reports errors.
// PARAMETERS
//  COLS     640    pixel bytes per packet (one line)
//  ROWS     480    valid row numbers 0..ROWS-1
//  SYNC_HI  8'hCA  first header byte
//  SYNC_LO  8'hFE  second header byte
// PORTS
//  clk        in   1   single clock; all logic in this domain
//  rst_n      in   1   asynchronous, active-low reset
//  enable     in   1   sampled only at packet start; 0 -> whole packet discarded
//  rx_valid   in   1   payload byte valid
//  rx_data    in   8   payload byte
//  rx_last    in   1   last byte of UDP payload
//  rx_ready   out  1   byte accepted when rx_valid & rx_ready
//  pix_valid  out  1   pixel write valid
//  pix_ready  in   1   sink ready; transfer when pix_valid & pix_ready
//  pix_data   out  8   pixel byte
//  pix_row    out  16  row from header
//  pix_col    out  16  column 0..COLS-1
//  pix_sof    out  1   with pixel row 0 col 0
//  pix_eol    out  1   with pixel col COLS-1
//  err_sync   out  1   1-cycle pulse: bad sync byte
//  err_len    out  1   1-cycle pulse: packet short or long
//  err_row    out  1   1-cycle pulse: row >= ROWS
//  pkt_cnt    out  16  good packets, wraps 16'hFFFF->0
//  debug      out  8   {3'b0, err_len, err_sync, state[2:0]}
// BEHAVIOUR
//  Reset: state HUNT; pix_valid, pix_sof, pix_eol, err_* = 0; pix_data/row/col = 0; pkt_cnt = 0.
//  States: HUNT -> SYNC2 -> ROW_HI -> ROW_LO -> DATA -> HUNT; any -> DROP on error; DROP -> HUNT.
//   HUNT: byte==SYNC_HI & enable -> SYNC2; else err_sync if byte!=SYNC_HI -> DROP (HUNT if rx_last).
//   SYNC2: byte==SYNC_LO -> ROW_HI, else err_sync -> DROP.
//   ROW_HI/ROW_LO: latch row; at ROW_LO, row>=ROWS -> err_row, DROP; else col<=0, DATA.
//   DATA: each byte -> output register, col++. rx_last with col==COLS-1 -> pkt_cnt++, HUNT.
//    rx_last earlier -> err_len, HUNT (pixels already emitted stay emitted). Byte COLS without
//    rx_last -> err_len, DROP, byte not emitted.
//   DROP: consume bytes until rx_last accepted -> HUNT.
//  rx_last in SYNC2/ROW_HI/ROW_LO -> err_len (SYNC2 with bad byte: err_sync only), HUNT.
//  enable=0 mid-packet has no effect on current packet.
//  rx_ready = 1 in all states except DATA; in DATA = !pix_valid | pix_ready (1-deep output reg).
//  Latency: accepted DATA byte appears on pix_* next cycle; pix_* held stable while pix_valid & !pix_ready.
//  err_* / pkt_cnt update in cycle after offending/final byte accepted; err pulses exactly 1 cycle.
//  Full throughput: 1 pixel/cycle with pix_ready held high; header costs 4 input cycles, no output.
//  Reset mid-packet: immediate return to reset values; next packet parsed from HUNT.
// STRUCTURE
//  Shared package (top_pkg): bus8_t/bus16_t (existing); add rx_state_t enum
//   {HUNT, SYNC2, ROW_HI, ROW_LO, DATA, DROP} and UDP_SYNC_HI/UDP_SYNC_LO constants shared with TX.
//  No sub-module: FSM, column counter, output register and error flags inline.
// TESTING
//  1 Good packet CA FE 00 05 + 640 bytes (col[7:0]), pix_ready=1 -> 640 writes row 5 col 0..639,
//    data==col[7:0], eol on col 639, pkt_cnt=1, no errors.
//  2 Row 0 packet -> pix_sof on col 0 only; four packets rows 0..3 back-to-back -> pkt_cnt=4, no gaps.
//  3 Bad sync CA 00 ... rx_last -> err_sync 1 pulse, zero pix writes; following good packet parsed.
//  4 Short packet (header + 100 bytes, rx_last) -> 100 writes, err_len pulse, pkt_cnt unchanged;
//    long packet (header + 650) -> 640 writes, err_len, rest dropped.
//  5 Row 480 header -> err_row, no writes; pix_ready random 50% -> every byte emitted once in order,
//    rx_ready low only while pix_valid & !pix_ready.
//  6 rst_n asserted mid-DATA -> outputs 0 asynchronously; enable=0 at packet start -> packet dropped
//    silently (no error pulses).

Source files
------------

// File: rtl/udp2rgb_depack_pkg.sv
// Shared types and constants for the RGB-over-UDP link (used by both TX packetizer and RX depacketizer).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package udp2rgb_depack_pkg;

  typedef logic [7:0]  bus8_t;
  typedef logic [15:0] bus16_t;

  // Header sync bytes; the TX packetizer emits these in this order.
  localparam bus8_t UDP_SYNC_HI = 8'hCA;
  localparam bus8_t UDP_SYNC_LO = 8'hFE;

  // Receive parser states. The encoding is visible on debug[2:0].
  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    SYNC2  = 3'd1,
    ROW_HI = 3'd2,
    ROW_LO = 3'd3,
    DATA   = 3'd4,
    DROP   = 3'd5
  } rx_state_t;

endpackage

// File: rtl/udp2rgb_depack.sv
// Parses a UDP payload stream (sync, sync, row hi, row lo, COLS pixels) into addressed pixel writes.
// Latency: an accepted pixel byte appears on pix_* the next cycle; errors and pkt_cnt also lag one cycle.
// Backpressure: 1-deep output register; rx_ready drops in DATA only while pix_valid & !pix_ready.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   enable                      sampled on the first byte of a packet; 0 discards the packet silently
//   rx_valid/rx_ready/rx_data/rx_last   payload byte stream from the UDP RX core
//   pix_valid/pix_ready/pix_data/pix_row/pix_col/pix_sof/pix_eol   pixel writes to the frame buffer
//   err_sync/err_len/err_row    single-cycle error pulses
//   pkt_cnt                     count of complete, well-formed packets (wraps)
//   debug                       {3'b0, err_len, err_sync, state}
module udp2rgb_depack
  import udp2rgb_depack_pkg::*;
#(
  parameter int    COLS    = 640,
  parameter int    ROWS    = 480,
  parameter bus8_t SYNC_HI = UDP_SYNC_HI,
  parameter bus8_t SYNC_LO = UDP_SYNC_LO
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   enable,
  input  logic   rx_valid,
  input  bus8_t  rx_data,
  input  logic   rx_last,
  output logic   rx_ready,
  output logic   pix_valid,
  input  logic   pix_ready,
  output bus8_t  pix_data,
  output bus16_t pix_row,
  output bus16_t pix_col,
  output logic   pix_sof,
  output logic   pix_eol,
  output logic   err_sync,
  output logic   err_len,
  output logic   err_row,
  output bus16_t pkt_cnt,
  output bus8_t  debug
);

  localparam bus16_t COLS16   = bus16_t'(COLS);
  localparam bus16_t LAST_COL = bus16_t'(COLS - 1);
  localparam bus16_t ROWS16   = bus16_t'(ROWS);

  rx_state_t state, state_nxt;
  bus8_t     row_hi;
  bus16_t    row;
  bus16_t    col;
  bus16_t    hdr_row;
  logic      rx_acc;

  // Decoded per-byte actions
  logic      pix_load;
  logic      start_data;
  logic      pkt_done;
  logic      set_sync;
  logic      set_len;
  logic      set_row;

  // Only DATA can stall: the output register must be free (or draining) to take a new pixel.
  assign rx_ready = (state == DATA) ? (!pix_valid || pix_ready) : 1'b1;
  assign rx_acc   = rx_valid && rx_ready;
  assign hdr_row  = {row_hi, rx_data};
  assign debug    = {3'b000, err_len, err_sync, state};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (rx_acc) begin
      case (state)
        HUNT: begin
          // A good first byte starts the packet even if it carries rx_last; anything
          // else (bad byte, or disabled) discards the rest of the payload.
          if (rx_data == SYNC_HI && enable) state_nxt = SYNC2;
          else if (!rx_last)                state_nxt = DROP;
        end
        SYNC2: begin
          if (rx_last)                   state_nxt = HUNT;
          else if (rx_data == SYNC_LO)   state_nxt = ROW_HI;
          else                           state_nxt = DROP;
        end
        ROW_HI: state_nxt = rx_last ? HUNT : ROW_LO;
        ROW_LO: begin
          if (rx_last)                   state_nxt = HUNT;
          else if (hdr_row >= ROWS16)    state_nxt = DROP;
          else                           state_nxt = DATA;
        end
        DATA: begin
          if (rx_last)                   state_nxt = HUNT;
          else if (col == COLS16)        state_nxt = DROP;
        end
        DROP: if (rx_last)               state_nxt = HUNT;
        default:                         state_nxt = HUNT;
      endcase
    end
  end

  // Output/action decode
  always_comb begin
    pix_load   = 1'b0;
    start_data = 1'b0;
    pkt_done   = 1'b0;
    set_sync   = 1'b0;
    set_len    = 1'b0;
    set_row    = 1'b0;
    if (rx_acc) begin
      case (state)
        HUNT:   set_sync = (rx_data != SYNC_HI);
        SYNC2: begin
          // A bad second sync byte reports only the sync error, even on rx_last.
          if (rx_data != SYNC_LO) set_sync = 1'b1;
          else                    set_len  = rx_last;
        end
        ROW_HI: set_len = rx_last;
        ROW_LO: begin
          if (rx_last)                set_len    = 1'b1;
          else if (hdr_row >= ROWS16) set_row    = 1'b1;
          else                        start_data = 1'b1;
        end
        DATA: begin
          // col == COLS means a full line already went out: this byte is surplus.
          if (col == COLS16) begin
            set_len = 1'b1;
          end else begin
            pix_load = 1'b1;
            if (rx_last) begin
              if (col == LAST_COL) pkt_done = 1'b1;
              else                 set_len  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: row latch, column counter, output register, error pulses, packet counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_hi    <= '0;
      row       <= '0;
      col       <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      err_sync  <= 1'b0;
      err_len   <= 1'b0;
      err_row   <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      err_sync <= set_sync;
      err_len  <= set_len;
      err_row  <= set_row;
      if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;

      if (rx_acc && state == ROW_HI) row_hi <= rx_data;

      if (start_data) begin
        row <= hdr_row;
        col <= '0;
      end else if (pix_load) begin
        col <= col + 16'd1;
      end

      if (pix_load) begin
        pix_valid <= 1'b1;
        pix_data  <= rx_data;
        pix_row   <= row;
        pix_col   <= col;
        pix_sof   <= (row == '0) && (col == '0);
        pix_eol   <= (col == LAST_COL);
      end else if (pix_ready) begin
        // Markers are cleared with valid so they never appear outside a pixel.
        pix_valid <= 1'b0;
        pix_sof   <= 1'b0;
        pix_eol   <= 1'b0;
      end
    end
  end

endmodule
